// File: rtl/id_stage_pkg.sv
// Shared definitions for the ID operand stage: opcode constants, forwarding
// select encodings, hazard FSM state encoding and instruction-decode helpers.
package id_stage_pkg;

  // Branch opcodes
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // Opcodes whose Rt field names a destination (immediates and loads),
  // so Rt is not read as a source operand.
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;

  // Forwarding select encodings; the fourth code falls back to the regfile
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_EXMEM   = 2'd1;
  localparam logic [1:0] FWD_MEMWB   = 2'd2;

  // Hazard FSM states
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } hz_state_e;

  // True when the opcode is a conditional branch that compares Rs and Rt
  function automatic logic is_branch(input logic [5:0] opcode);
    return (opcode == OP_BEQ) || (opcode == OP_BNE);
  endfunction

  // True when Rt is a destination field rather than a source operand
  function automatic logic rt_is_dest(input logic [5:0] opcode);
    logic res;
    case (opcode)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
      OP_LB, OP_LH, OP_LW: res = 1'b1;
      default:             res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/id_hazard_fsm.sv
// Hazard detection for the ID stage: works out how many stall cycles the
// instruction in ID needs, sequences them with a RUN/HOLD FSM, and keeps an
// optional stall-cycle counter (enabled by defining STALL_PERF_CNT_EN).
module id_hazard_fsm
  import id_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [5:0]            Opcode,
  input  logic [REG_ADDR_W-1:0] Rs,
  input  logic [REG_ADDR_W-1:0] Rt,
  input  logic                  IFID_Valid,
  input  logic                  IDEX_RegWrite,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_DstReg,
  input  logic                  Flush,
  output logic                  Stall,
  output logic [31:0]           StallCount
);

  hz_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] need;
  logic [1:0] need_m1;
  logic       branch;
  logic       rt_src;
  logic       dep;
  logic       stall_raw;

  assign branch = is_branch(Opcode);
  assign rt_src = ~rt_is_dest(Opcode);

  // The register $0 never carries a real dependence
  assign dep = (IDEX_DstReg != '0) &&
               ((IDEX_DstReg == Rs) || (rt_src && (IDEX_DstReg == Rt)));

  // Stall-cycle demand of the ID instruction; only looked at while running
  always_comb begin
    need = 2'd0;
    if (IFID_Valid && (state_q == ST_RUN)) begin
      if (IDEX_MemRead && dep) begin
        need = branch ? 2'd2 : 2'd1;
      end else if (branch && IDEX_RegWrite && dep) begin
        need = 2'd1;
      end
    end
  end

  assign need_m1 = need - 2'd1;

  // Next-state logic; a flush overrides everything and returns to RUN
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_raw = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (need != 2'd0) begin
          stall_raw = 1'b1;
          cnt_d     = need_m1;
          state_d   = (need_m1 != 2'd0) ? ST_HOLD : ST_RUN;
        end
      end
      ST_HOLD: begin
        stall_raw = 1'b1;
        cnt_d     = (cnt_q != 2'd0) ? (cnt_q - 2'd1) : 2'd0;
        if (cnt_q <= 2'd1) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = 2'd0;
      end
    endcase
    if (Flush) begin
      state_d = ST_RUN;
      cnt_d   = 2'd0;
    end
  end

  // A taken branch/jump kills the ID instruction, so nothing is held
  assign Stall = stall_raw & ~Flush;

  // FSM state and stall counter registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Saturating count of stalled cycles
  always_comb begin
    perf_d = perf_q;
    if (Stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Performance counter register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      perf_q <= 32'd0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign StallCount = perf_q;
`else
  assign StallCount = 32'd0;
`endif

endmodule

// File: rtl/id_operand_stage.sv
// ID operand stage: applies the forwarding selects to pick each operand,
// compares them for branches, and loads the ID/EX pipeline register, inserting
// bubbles on stall or flush. Define STALL_PERF_CNT_EN to build the stall counter.
module id_operand_stage
  import id_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [31:0]           IFID_Instruction,
  input  logic                  IFID_Valid,
  input  logic [DATA_W-1:0]     ReadData1,
  input  logic [DATA_W-1:0]     ReadData2,
  input  logic [1:0]            ReadRegSelA,
  input  logic [1:0]            ReadRegSelB,
  input  logic [DATA_W-1:0]     EXMEM_ALUResult,
  input  logic [DATA_W-1:0]     MEMWB_WriteData,
  input  logic                  IDEX_RegWrite,
  input  logic                  IDEX_MemRead,
  input  logic [REG_ADDR_W-1:0] IDEX_DstReg,
  input  logic                  Flush,
  output logic                  Stall,
  output logic                  BranchEq,
  output logic [DATA_W-1:0]     IDEX_OperandA,
  output logic [DATA_W-1:0]     IDEX_OperandB,
  output logic [31:0]           IDEX_Instruction,
  output logic                  IDEX_Valid,
  output logic [31:0]           StallCount
);

  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] opa_q, opa_d;
  logic [DATA_W-1:0] opb_q, opb_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              stall;

  // Operand source chosen by a forwarding select
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] rf,
    input logic [DATA_W-1:0] exmem,
    input logic [DATA_W-1:0] memwb
  );
    logic [DATA_W-1:0] res;
    case (sel)
      FWD_EXMEM: res = exmem;
      FWD_MEMWB: res = memwb;
      default:   res = rf;
    endcase
    return res;
  endfunction

  assign op_a     = fwd_pick(ReadRegSelA, ReadData1, EXMEM_ALUResult, MEMWB_WriteData);
  assign op_b     = fwd_pick(ReadRegSelB, ReadData2, EXMEM_ALUResult, MEMWB_WriteData);
  assign BranchEq = (op_a == op_b);

  id_hazard_fsm #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .Clk           (Clk),
    .Rst_n         (Rst_n),
    .Opcode        (IFID_Instruction[31:26]),
    .Rs            (REG_ADDR_W'(IFID_Instruction[25:21])),
    .Rt            (REG_ADDR_W'(IFID_Instruction[20:16])),
    .IFID_Valid    (IFID_Valid),
    .IDEX_RegWrite (IDEX_RegWrite),
    .IDEX_MemRead  (IDEX_MemRead),
    .IDEX_DstReg   (IDEX_DstReg),
    .Flush         (Flush),
    .Stall         (stall),
    .StallCount    (StallCount)
  );

  assign Stall = stall;

  // ID/EX next value: bubble on flush or stall (operands held), else capture
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (Flush || stall) begin
      instr_d = 32'd0;
      valid_d = 1'b0;
    end else begin
      opa_d   = op_a;
      opb_d   = op_b;
      instr_d = IFID_Instruction;
      valid_d = IFID_Valid;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      instr_q <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

  assign IDEX_OperandA    = opa_q;
  assign IDEX_OperandB    = opb_q;
  assign IDEX_Instruction = instr_q;
  assign IDEX_Valid       = valid_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_id_operand_stage;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] IFID_Instruction;
  logic        IFID_Valid;
  logic [31:0] ReadData1, ReadData2;
  logic [1:0]  ReadRegSelA, ReadRegSelB;
  logic [31:0] EXMEM_ALUResult, MEMWB_WriteData;
  logic        IDEX_RegWrite, IDEX_MemRead;
  logic [4:0]  IDEX_DstReg;
  logic        Flush;
  logic        Stall, BranchEq;
  logic [31:0] IDEX_OperandA, IDEX_OperandB, IDEX_Instruction;
  logic        IDEX_Valid;
  logic [31:0] StallCount;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  // Model state: remaining held stall cycles and the expected ID/EX contents
  int          m_rem;
  logic [31:0] m_opa, m_opb, m_ins, m_cnt;
  logic        m_valid;

  id_operand_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .IFID_Instruction (IFID_Instruction),
    .IFID_Valid       (IFID_Valid),
    .ReadData1        (ReadData1),
    .ReadData2        (ReadData2),
    .ReadRegSelA      (ReadRegSelA),
    .ReadRegSelB      (ReadRegSelB),
    .EXMEM_ALUResult  (EXMEM_ALUResult),
    .MEMWB_WriteData  (MEMWB_WriteData),
    .IDEX_RegWrite    (IDEX_RegWrite),
    .IDEX_MemRead     (IDEX_MemRead),
    .IDEX_DstReg      (IDEX_DstReg),
    .Flush            (Flush),
    .Stall            (Stall),
    .BranchEq         (BranchEq),
    .IDEX_OperandA    (IDEX_OperandA),
    .IDEX_OperandB    (IDEX_OperandB),
    .IDEX_Instruction (IDEX_Instruction),
    .IDEX_Valid       (IDEX_Valid),
    .StallCount       (StallCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(int rs, int rt, int rd);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] fwd(logic [1:0] sel, logic [31:0] rf);
    if (sel == 2'd1) return EXMEM_ALUResult;
    if (sel == 2'd2) return MEMWB_WriteData;
    return rf;
  endfunction

  // Stall cycles needed by the ID instruction given what sits in EX
  function automatic int calc_need();
    int op, rs, rt, dst;
    bit br, rt_src, dep;
    op  = int'(IFID_Instruction[31:26]);
    rs  = int'(IFID_Instruction[25:21]);
    rt  = int'(IFID_Instruction[20:16]);
    dst = int'(IDEX_DstReg);
    br  = (op == 4) || (op == 5);
    rt_src = !(op inside {8, 9, 10, 11, 12, 13, 14, 15, 32, 33, 35});
    dep = (dst != 0) && ((dst == rs) || (rt_src && dst == rt));
    if (!IFID_Valid) return 0;
    if (IDEX_MemRead && dep) return br ? 2 : 1;
    if (br && IDEX_RegWrite && dep) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_opa = 0; m_opb = 0; m_ins = 0; m_valid = 0; m_cnt = 0;
  endtask

  task automatic check_regs(input string pfx);
    check({pfx, "_opa"},   IDEX_OperandA,    m_opa);
    check({pfx, "_opb"},   IDEX_OperandB,    m_opb);
    check({pfx, "_instr"}, IDEX_Instruction, m_ins);
    check({pfx, "_valid"}, {31'd0, IDEX_Valid}, {31'd0, m_valid});
    check({pfx, "_scnt"},  StallCount,       m_cnt);
  endtask

  // One clock with the currently driven inputs; checks comb and registered outputs
  task automatic step();
    int need;
    logic s_exp;
    logic [31:0] a, b;
    #1;
    a = fwd(ReadRegSelA, ReadData1);
    b = fwd(ReadRegSelB, ReadData2);
    need  = (m_rem > 0) ? 0 : calc_need();
    s_exp = ((m_rem > 0) || (need > 0)) && !Flush;
    check("stall", {31'd0, Stall}, {31'd0, s_exp});
    check("beq", {31'd0, BranchEq}, {31'd0, (a == b)});
    @(posedge Clk);
    if (Flush) begin
      m_rem = 0; m_valid = 0; m_ins = 0;
    end else if (m_rem > 0) begin
      m_rem--; m_valid = 0; m_ins = 0;
    end else if (need > 0) begin
      m_rem = need - 1; m_valid = 0; m_ins = 0;
    end else begin
      m_opa = a; m_opb = b; m_ins = IFID_Instruction; m_valid = IFID_Valid;
    end
`ifdef STALL_PERF_CNT_EN
    if (s_exp && m_cnt != 32'hFFFF_FFFF) m_cnt++;
`endif
    #1;
    check_regs("idex");
    n_txn++;
    $display("txn %0d ins=%08h stall=%0b flush=%0b -> valid=%0b opa=%08h opb=%08h",
             n_txn, IFID_Instruction, s_exp, Flush, IDEX_Valid, IDEX_OperandA, IDEX_OperandB);
  endtask

  task automatic set_ex(input logic rw, input logic mr, input int dst);
    IDEX_RegWrite = rw; IDEX_MemRead = mr; IDEX_DstReg = dst[4:0];
  endtask

  task automatic set_id(input logic v, input logic [31:0] ins);
    IFID_Valid = v; IFID_Instruction = ins;
  endtask

  logic [31:0] mux_exp [4];
  int stall_seen;

  initial begin
    Rst_n = 1'b0;
    set_id(0, 32'd0);
    ReadData1 = 0; ReadData2 = 0; ReadRegSelA = 0; ReadRegSelB = 0;
    EXMEM_ALUResult = 0; MEMWB_WriteData = 0; Flush = 0;
    set_ex(0, 0, 0);
    model_reset();

    // Reset state
    #12;
    check_regs("reset");
    check("reset_stall", {31'd0, Stall}, 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Forwarding mux for operand A
    ReadData1 = 32'h11; ReadData2 = 32'h44;
    EXMEM_ALUResult = 32'h22; MEMWB_WriteData = 32'h33;
    mux_exp[0] = 32'h11; mux_exp[1] = 32'h22; mux_exp[2] = 32'h33; mux_exp[3] = 32'h11;
    set_id(1, rtype(1, 2, 3));
    for (int s = 0; s < 4; s++) begin
      ReadRegSelA = s[1:0];
      step();
      check("mux_a", IDEX_OperandA, mux_exp[s]);
    end
    ReadRegSelA = 0;

    // Load-use: lw $8 in EX, add $9,$8,$10 in ID -> one bubble
    set_ex(1, 1, 8);
    set_id(1, rtype(8, 10, 9));
    step();
    check("lu_bubble", {31'd0, IDEX_Valid}, 32'd0);
    set_ex(0, 0, 0);
    step();
    check("lu_capture", {31'd0, IDEX_Valid}, 32'd1);
    check("lu_instr", IDEX_Instruction, rtype(8, 10, 9));

    // Branch after load: lw $8, beq $8,$0 -> two stall cycles
    set_ex(1, 1, 8);
    set_id(1, itype(4, 8, 0, 3));
    stall_seen = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (Stall) stall_seen++;
      step();
      set_ex(0, 0, 0);
    end
    check("bl_stalls", stall_seen, 32'd2);
    check("bl_capture", {31'd0, IDEX_Valid}, 32'd1);

    // Flush during the first HOLD cycle of a branch-after-load
    set_ex(1, 1, 8);
    set_id(1, itype(5, 8, 0, 3));
    step();
    set_ex(0, 0, 0);
    Flush = 1'b1;
    #1;
    check("fl_stall", {31'd0, Stall}, 32'd0);
    step();
    check("fl_valid", {31'd0, IDEX_Valid}, 32'd0);
    Flush = 1'b0;
    set_id(1, rtype(1, 2, 3));
    #1;
    check("fl_no_second", {31'd0, Stall}, 32'd0);
    step();

    // $0 destination and non-source Rt never stall
    set_ex(1, 1, 0);
    set_id(1, rtype(0, 0, 9));
    step();
    set_ex(1, 1, 8);
    set_id(1, itype(8, 9, 8, 4));
    #1;
    check("addi_nostall", {31'd0, Stall}, 32'd0);
    step();

    // Reset asserted while holding a branch-after-load stall
    set_ex(1, 1, 8);
    set_id(1, itype(4, 8, 0, 3));
    step();
    set_ex(0, 0, 0);
    set_id(0, 32'd0);
    Rst_n = 1'b0;
    model_reset();
    #1;
    check_regs("rst_mid");
    check("rst_mid_run", {31'd0, Stall}, 32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;

    // Load-use plus branch-after-load sequence after reset: three stall cycles
    set_ex(1, 1, 8); set_id(1, rtype(8, 10, 9)); step();
    set_ex(0, 0, 0); step();
    set_ex(1, 1, 8); set_id(1, itype(4, 8, 0, 3)); step();
    set_ex(0, 0, 0); step(); step();
`ifdef STALL_PERF_CNT_EN
    check("perf_cnt", StallCount, 32'd3);
`else
    check("perf_cnt", StallCount, 32'd0);
`endif

    // Randomized traffic
    for (int t = 0; t < 2000; t++) begin
      int opsel;
      int ops [8] = '{0, 4, 5, 8, 15, 35, 43, 33};
      opsel = $urandom_range(0, 7);
      set_id(($urandom_range(0, 9) != 0),
             itype(ops[opsel], $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535)));
      ReadData1 = $urandom_range(0, 3);
      ReadData2 = ($urandom_range(0, 3) == 0) ? ReadData1 : $urandom();
      EXMEM_ALUResult = $urandom_range(0, 3);
      MEMWB_WriteData = $urandom_range(0, 3);
      ReadRegSelA = 2'($urandom_range(0, 3));
      ReadRegSelB = 2'($urandom_range(0, 3));
      set_ex(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      Flush = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_operand_stage.md
Name: id_operand_stage

Overview:
- Sits directly downstream of the ID-stage forwarding unit.
- Consumes its ReadRegSelA/ReadRegSelB selects and applies them to choose each operand from the register file, the EX/MEM result or the MEM/WB write-back value.
- Detects load-use and branch-operand hazards, stalls IF/ID, inserts bubbles, and registers the selected operands plus the instruction into the ID/EX pipeline register.

Parameters:
- DATA_W, 32, operand/data width
- REG_ADDR_W, 5, register-specifier width

Ports:
- Clk  in  1  pipeline clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- IFID_Instruction  in  32  instruction in ID
- IFID_Valid  in  1  IF/ID slot holds a real instruction
- ReadData1  in  DATA_W  register file port A (Rs)
- ReadData2  in  DATA_W  register file port B (Rt)
- ReadRegSelA  in  2  forwarding select for A: 0 regfile, 1 EX/MEM, 2 MEM/WB, 3 treated as 0
- ReadRegSelB  in  2  forwarding select for B, same encoding
- EXMEM_ALUResult  in  DATA_W  EX/MEM forwarded value
- MEMWB_WriteData  in  DATA_W  MEM/WB forwarded value
- IDEX_RegWrite  in  1  instruction now in EX writes a register
- IDEX_MemRead  in  1  instruction now in EX is a load
- IDEX_DstReg  in  REG_ADDR_W  destination of instruction now in EX
- Flush  in  1  branch/jump taken; kill the ID-stage instruction
- Stall  out  1  hold PC and IF/ID this cycle
- BranchEq  out  1  combinational: forwarded A == forwarded B
- IDEX_OperandA  out  DATA_W  registered operand A
- IDEX_OperandB  out  DATA_W  registered operand B
- IDEX_Instruction  out  32  registered instruction
- IDEX_Valid  out  1  registered valid
- StallCount  out  32  stall-cycle counter (optional feature)

Behaviour:
- Reset: Rst_n low asynchronously clears every register. All IDEX_* outputs are 0, StallCount is 0, FSM is RUN, stall counter is 0.
- Operand mux (combinational): opA/opB are chosen per select. Select 3 behaves as select 0. BranchEq compares opA and opB.
- Rs = IFID_Instruction[25:21]. Rt = IFID_Instruction[20:16]. Branch = opcode 000100 (beq) or 000101 (bne).
- Rt-use: Rt counts as a source unless the opcode is one of 001000, 001001, 001010, 001011, 001100, 001101, 001110, 001111, 100000, 100001, 100011.
- Dependence (dep): IDEX_DstReg is nonzero and equals Rs, or equals Rt when Rt counts as a source.
- Hazard, evaluated only when IFID_Valid is high and the FSM is in RUN:
  - load-use: IDEX_MemRead and dep gives need = 1; a branch gives need = 2.
  - branch-after-ALU: Branch and IDEX_RegWrite and !IDEX_MemRead and dep gives need = 1.
  - Otherwise need = 0.
- FSM states: RUN and HOLD, with a 2-bit counter cnt.
  - RUN, need > 0: Stall = 1 combinationally this cycle; a bubble is written to ID/EX; cnt <= need-1; the next state is HOLD if need-1 > 0, else RUN.
  - HOLD: Stall = 1, a bubble is written, cnt decrements, and the FSM returns to RUN when cnt reaches 0.
  - HOLD does not re-evaluate hazards.
- ID/EX register, per rising edge, in priority order:
  - Flush: bubble, FSM forced to RUN, cnt cleared. Stall is deasserted in that cycle.
  - Stall: bubble.
  - Otherwise capture opA, opB, IFID_Instruction and IFID_Valid.
- Bubble: IDEX_Valid = 0, IDEX_Instruction = 0, operands hold their previous value.
- Latency: one cycle from ID inputs to IDEX_* outputs.
- Rst_n asserted mid-stall aborts the stall immediately.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- Defined: StallCount increments by 1, saturating at 0xFFFFFFFF, on every cycle with Stall = 1. Flush cycles are not counted.
- Undefined: no counter is built and StallCount is tied to 0.

Decomposition:
- Shared package id_stage_pkg: opcode constants, the Rt-as-destination opcode list, FWD_REGFILE/FWD_EXMEM/FWD_MEMWB select encodings, FSM state encoding.
- One sub-module, id_hazard_fsm: hazard detection, need computation, RUN/HOLD FSM and counter, and the optional counter. The top level keeps the muxes, the comparator and the ID/EX register.

Test Plan:
- Forwarding mux: ReadData1=0x11, EXMEM_ALUResult=0x22, MEMWB_WriteData=0x33; drive ReadRegSelA=0,1,2,3 -> IDEX_OperandA is 0x11, 0x22, 0x33, 0x11 one cycle later.
- Load-use: EX holds lw to $8 (IDEX_MemRead=1, IDEX_DstReg=8); ID holds add $9,$8,$10 -> Stall=1 for exactly 1 cycle, one bubble (IDEX_Valid=0), then add captured with IDEX_Valid=1.
- Branch after load: EX holds lw $8; ID holds beq $8,$0 -> Stall=1 for 2 consecutive cycles, 2 bubbles, FSM back to RUN.
- Flush priority: Flush=1 during the first HOLD cycle of the branch-after-load case -> IDEX_Valid=0, Stall deasserts the same cycle, no second stall cycle.
- Zero register / non-source Rt: EX holds lw $0, or ID holds addi $8,$9,4 with EX lw $8 -> Stall=0.
- Reset mid-stall: assert Rst_n=0 in HOLD -> all outputs 0 immediately, FSM RUN; with STALL_PERF_CNT_EN, StallCount=0 after reset and equals 3 after the load-use plus branch-after-load sequence.
